// File: rtl/arb_mux_reg.sv
// N-way valid/ready arbiter (fixed-priority or round-robin) into one output register; parity via ARB_MUX_REG_PARITY_EN.
// Latency: one cycle from input handshake to OutValid, full 1 beat/cycle throughput.
// Backpressure: OutValid & !OutReady freezes the output register and deasserts every InReady.
module arb_mux_reg #(
    parameter int WIDTH   = 32,
    parameter int NUM_CH  = 4,
    parameter int RR_MODE = 1,
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    Clk,
    input  logic                    RstN,
    input  logic [NUM_CH-1:0]       InValid,
    input  logic [NUM_CH*WIDTH-1:0] InData,
    output logic [NUM_CH-1:0]       InReady,
    output logic                    OutValid,
    output logic [WIDTH-1:0]        OutData,
    output logic [SEL_W-1:0]        OutSel,
    input  logic                    OutReady,
    output logic                    OutPar
);

    localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_CH - 1);

    logic                r_vld;
    logic [WIDTH-1:0]    r_dat;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    r_last;

    logic                w_load_en;
    logic                w_any_gnt;
    logic [NUM_CH-1:0]   w_grant;
    logic [SEL_W-1:0]    w_gnt_idx;
    logic [WIDTH-1:0]    w_gnt_dat;

    // k-th channel in search order; round-robin starts just after the last winner
    function automatic int cand(input int k, input logic [SEL_W-1:0] last);
        if (RR_MODE != 0) begin
            return (int'(last) + 1 + k) % NUM_CH;
        end
        return k;
    endfunction

    assign w_load_en = !r_vld || OutReady;

    always_comb begin
        w_grant   = '0;
        w_gnt_idx = '0;
        w_any_gnt = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_any_gnt && InValid[cand(k, r_last)]) begin
                w_any_gnt                = 1'b1;
                w_grant[cand(k, r_last)] = 1'b1;
                w_gnt_idx                = SEL_W'(cand(k, r_last));
            end
        end
    end

    assign w_gnt_dat = InData[int'(w_gnt_idx)*WIDTH +: WIDTH];
    assign InReady   = w_grant & {NUM_CH{w_load_en}};

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_vld  <= 1'b0;
            r_dat  <= '0;
            r_sel  <= '0;
            r_last <= LAST_RST;
        end else if (w_load_en) begin
            r_vld <= w_any_gnt;
            if (w_any_gnt) begin
                r_dat <= w_gnt_dat;
                r_sel <= w_gnt_idx;
                if (RR_MODE != 0) begin
                    r_last <= w_gnt_idx;
                end
            end
        end
    end

    assign OutValid = r_vld;
    assign OutData  = r_dat;
    assign OutSel   = r_sel;

`ifdef ARB_MUX_REG_PARITY_EN
    logic r_par;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_par <= 1'b0;
        end else if (w_load_en && w_any_gnt) begin
            r_par <= ^w_gnt_dat;
        end
    end

    assign OutPar = r_par;
`else
    assign OutPar = 1'b0;
`endif

endmodule

// File: tb/tb_arb_mux_reg.sv
// Bench for arb_mux_reg: round-robin instance scoreboarded every cycle, fixed-priority instance
// checked against a vector table, plus reset, backpressure and parity sequences.
module tb_arb_mux_reg;

    localparam int W  = 32;
    localparam int NC = 4;

    logic          Clk = 1'b0;
    logic          RstN;
    logic [NC-1:0] InValid;
    logic [NC*W-1:0] InData;
    logic          OutReady;
    logic [W-1:0]  chdata [NC];

    logic [NC-1:0] f_rdy, r_rdy;
    logic          f_vld, r_vld;
    logic [W-1:0]  f_dat, r_dat;
    logic [1:0]    f_sel, r_sel;
    logic          f_par, r_par;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    assign InData = {chdata[3], chdata[2], chdata[1], chdata[0]};

    arb_mux_reg #(.WIDTH(W), .NUM_CH(NC), .RR_MODE(0)) u_fix (
        .Clk(Clk), .RstN(RstN), .InValid(InValid), .InData(InData), .InReady(f_rdy),
        .OutValid(f_vld), .OutData(f_dat), .OutSel(f_sel), .OutReady(OutReady), .OutPar(f_par)
    );

    arb_mux_reg #(.WIDTH(W), .NUM_CH(NC), .RR_MODE(1)) u_rr (
        .Clk(Clk), .RstN(RstN), .InValid(InValid), .InData(InData), .InReady(r_rdy),
        .OutValid(r_vld), .OutData(r_dat), .OutSel(r_sel), .OutReady(OutReady), .OutPar(r_par)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_par(input logic [W-1:0] d);
`ifdef ARB_MUX_REG_PARITY_EN
        return ^d;
`else
        return (d == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // Scoreboard for the round-robin instance: expected beats queued at the input handshake
    typedef struct packed {
        logic [W-1:0] dat;
        logic [1:0]   sel;
        logic         par;
    } beat_t;

    beat_t q[$];
    logic  m_vld  = 1'b0;
    int    m_last = NC - 1;

    always @(posedge Clk) begin
        int    g;
        logic  load;
        beat_t b;
        if (!RstN) begin
            m_vld  = 1'b0;
            m_last = NC - 1;
            q.delete();
        end else begin
            load = !m_vld || OutReady;
            g = -1;
            for (int k = 0; k < NC; k++) begin
                if (g < 0 && InValid[(m_last + 1 + k) % NC]) g = (m_last + 1 + k) % NC;
            end
            check("rr_inready", r_rdy, (g >= 0 && load) ? (64'd1 << g) : 64'd0);
            check("rr_outvalid", r_vld, m_vld);
            if (m_vld) begin
                if (q.size() == 0) begin
                    check("rr_sb_empty", 1, 0);
                end else begin
                    check("rr_outdata", r_dat, q[0].dat);
                    check("rr_outsel", r_sel, q[0].sel);
                    check("rr_outpar", r_par, q[0].par);
                    if (OutReady) void'(q.pop_front());
                end
            end
            if (load) begin
                if (g >= 0) begin
                    b.dat = chdata[g];
                    b.sel = 2'(g);
                    b.par = exp_par(chdata[g]);
                    q.push_back(b);
                    m_last = g;
                end
                m_vld = (g >= 0);
            end
        end
    end

    typedef struct packed {
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] f_rdy;
        logic       ovld;
        logic [1:0] rr_sel;
        logic [1:0] fx_sel;
    } vec_t;

    vec_t vt [0:20];

    initial begin
        vt[0]  = {4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1};
        vt[1]  = {4'b1010, 1'b1, 4'b0010, 1'b1, 2'd3, 2'd1};
        vt[2]  = {4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd3};
        vt[3]  = {4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 2'd3};
        vt[4]  = {4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd0};
        vt[5]  = {4'b1111, 1'b1, 4'b0001, 1'b1, 2'd1, 2'd0};
        vt[6]  = {4'b1111, 1'b1, 4'b0001, 1'b1, 2'd2, 2'd0};
        vt[7]  = {4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 2'd0};
        vt[8]  = {4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd0};
        vt[9]  = {4'b1111, 1'b1, 4'b0001, 1'b1, 2'd1, 2'd0};
        vt[10] = {4'b1111, 1'b1, 4'b0001, 1'b1, 2'd2, 2'd0};
        vt[11] = {4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 2'd0};
        vt[12] = {4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd0};
        vt[13] = {4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0, 2'd0};
        vt[14] = {4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0, 2'd0};
        vt[15] = {4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0, 2'd0};
        vt[16] = {4'b0101, 1'b1, 4'b0001, 1'b1, 2'd2, 2'd0};
        vt[17] = {4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd3};
        vt[18] = {4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2};
        vt[19] = {4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd0};
        vt[20] = {4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd0};

        chdata[0] = 32'h0000_00A0;
        chdata[1] = 32'h0000_0011;
        chdata[2] = 32'h0000_0022;
        chdata[3] = 32'h0000_0033;
        InValid   = '0;
        OutReady  = 1'b0;
        RstN      = 1'b0;
        #1;
        check("rst_fx_vld", f_vld, 0);
        check("rst_rr_vld", r_vld, 0);
        check("rst_rr_dat", r_dat, 0);
        check("rst_rr_sel", r_sel, 0);
        check("rst_par", r_par, 0);
        repeat (2) @(posedge Clk);
        #1 RstN = 1'b1;

        for (int i = 0; i <= 20; i++) begin
            InValid  = vt[i].vld;
            OutReady = vt[i].ordy;
            #1;
            check($sformatf("fx_inready[%0d]", i), f_rdy, vt[i].f_rdy);
            @(posedge Clk);
            #1;
            check($sformatf("fx_vld[%0d]", i), f_vld, vt[i].ovld);
            check($sformatf("fx_sel[%0d]", i), f_sel, vt[i].fx_sel);
            check($sformatf("rr_vld[%0d]", i), r_vld, vt[i].ovld);
            check($sformatf("rr_sel[%0d]", i), r_sel, vt[i].rr_sel);
            if (vt[i].ovld) begin
                check($sformatf("fx_dat[%0d]", i), f_dat, chdata[vt[i].fx_sel]);
                check($sformatf("rr_dat[%0d]", i), r_dat, chdata[vt[i].rr_sel]);
            end
        end

        // Asynchronous reset while a beat is held and stalled
        InValid  = 4'b0001;
        OutReady = 1'b0;
        @(posedge Clk);
        #1;
        check("pre_rst_vld", r_vld, 1);
        RstN = 1'b0;
        #1;
        check("arst_rr_vld", r_vld, 0);
        check("arst_rr_dat", r_dat, 0);
        check("arst_rr_sel", r_sel, 0);
        check("arst_fx_vld", f_vld, 0);
        check("arst_fx_dat", f_dat, 0);
        InValid = '0;
        @(posedge Clk);
        #1 RstN = 1'b1;
        OutReady = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("idle_vld", r_vld, 0);
        check("idle_inready", r_rdy, 0);

        // Parity on two consecutive loads
        chdata[0] = 32'h0000_0007;
        InValid   = 4'b0001;
        @(posedge Clk);
        #1;
        check("par_7", r_par, exp_par(32'h0000_0007));
        check("par_7_fx", f_par, exp_par(32'h0000_0007));
        chdata[0] = 32'h0000_0003;
        @(posedge Clk);
        #1;
        check("par_3", r_par, exp_par(32'h0000_0003));
        check("par_3_dat", r_dat, 32'h0000_0003);
        InValid = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("drain_vld", r_vld, 0);
        check("drain_sb", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_mux_reg.md
Name: arb_mux_reg

Overview:
- Parametrised N-way arbitrated multiplexer with a registered output stage and valid/ready handshakes on every channel. This is the sequential successor to the 2:1 data-path mux.
- Sits where several producers share one consumer, e.g. instruction-fetch and load/store requests sharing one memory port, or several writeback sources sharing one register-file write port.
- Selects one valid input per cycle (fixed-priority or round-robin), captures it into an output register and holds it until the consumer accepts it.

Parameters:
- WIDTH, 32, data width of each channel in bits.
- NUM_CH, 4, number of input channels, 1..16.
- RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- SEL_W, $clog2(NUM_CH) (minimum 1), width of the OutSel port; derived, not overridden.

Ports:
- Clk  in  1  rising-edge clock; the only clock.
- RstN  in  1  asynchronous, active-low reset.
- InValid  in  NUM_CH  per-channel request valid.
- InData  in  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- InReady  out  NUM_CH  per-channel accept; a beat transfers when InValid[i] & InReady[i].
- OutValid  out  1  output register holds a beat.
- OutData  out  WIDTH  registered data.
- OutSel  out  SEL_W  index of the channel that supplied OutData.
- OutReady  in  1  consumer accepts the beat when OutValid & OutReady.
- OutPar  out  1  even parity of OutData (see Optional Feature).

Behaviour:
- Reset (RstN low, asynchronous):
  - Outputs: OutValid=0, OutData=0, OutSel=0, OutPar=0.
  - Round-robin pointer Last = NUM_CH-1, so channel 0 has first priority.
  - Reset mid-transfer drops the held beat without delivering it.
- Load enable: LoadEn = !OutValid | OutReady. This gives a single-stage pipeline with full throughput of 1 beat/cycle.
- Grant (combinational):
  - RR_MODE=0: the lowest-index channel with InValid set.
  - RR_MODE=1: the first channel with InValid set, searching upward from Last+1 modulo NUM_CH.
  - At most one grant bit is ever set.
- InReady[i] = Grant[i] & LoadEn. InReady may depend on InValid; there is no combinational path from InValid to OutValid.
- On a rising edge with LoadEn high:
  - Any grant: OutValid<=1, OutData<=InData of the granted channel, OutSel<=granted index. In RR mode, Last<=granted index.
  - No grant: OutValid<=0. OutData, OutSel and Last hold.
- On a rising edge with LoadEn low (OutValid & !OutReady): all registers hold. OutData and OutSel stay stable while stalled.
- Latency: one cycle from input handshake to OutValid.
- Last advances only on an actual grant, never on idle cycles.
- Wrap-around: a grant to channel NUM_CH-1 makes channel 0 the next priority.
- Simultaneous OutReady with a new grant: the old beat leaves and the new beat loads in the same edge; no bubble.
- NUM_CH=1: degenerates to a 1-deep pipeline register. OutSel is constant 0 and RR_MODE has no effect.
- Fairness (RR_MODE=1): with every channel continuously valid and OutReady held high, each channel is granted exactly once in every NUM_CH consecutive beats.

Optional Feature:
- Macro: ARB_MUX_REG_PARITY_EN.
- Defined: OutPar is registered alongside OutData as the XOR of the loaded data. It resets to 0, updates only on a load and holds while stalled.
- Undefined: OutPar is tied to 0 and no parity logic is generated.
- The port list is identical in both builds.

Test Plan:
- Reset and idle: RstN=0 applied mid-transfer, with OutValid=1 and OutReady=0 -> OutValid, OutData, OutSel go to 0 immediately without waiting for a clock edge. After release with no inputs valid -> OutValid stays 0 and InReady=0.
- Fixed priority (RR_MODE=0, NUM_CH=4): InValid=4'b1010, InData[1]=32'h11, InData[3]=32'h33, OutReady=1 -> next cycle OutValid=1, OutData=32'h11, OutSel=1. Channel 3 is granted only after channel 1 drops its valid.
- Round-robin fairness (RR_MODE=1): InValid=4'b1111, OutReady=1 for 8 cycles -> OutSel sequence 0,1,2,3,0,1,2,3 with no bubbles.
- Backpressure: OutReady=0 for 3 cycles with channels 0 and 2 valid -> InReady=0 and OutData/OutSel frozen. OutReady=1 -> the next beat is delivered on the following edge.
- Wrap and skip (RR_MODE=1): Last=3, InValid=4'b0100 -> channel 2 is granted and Last becomes 2. Then InValid=4'b0011 -> channel 0 is granted (search 3,0,1).
- Parity: with ARB_MUX_REG_PARITY_EN defined, load 32'h0000_0007 -> OutPar=1, then load 32'h0000_0003 -> OutPar=0. With the macro undefined -> OutPar=0 throughout.
